id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the FMRT Mini Core, between the IF/ID latch and EX.
//  - Extracts rs1/rs2/rd from the fetched RV32I word and drives the gpr read ports.
//  - Forwards in-flight EX/MEM results over gpr read data; generates the immediate.
//  - Detects load-use hazards and registers the decoded bundle into the ID/EX latch.
// PARAMETERS
//  XLEN      32  data/address width
//  REG_AW     5  register address width
// PORTS
//  clk           in   1       clock, all state on rising edge
//  reset_        in   1       asynchronous, active-low reset
//  if_pc         in   XLEN    PC of fetched instruction
//  if_insn       in   32      fetched instruction word
//  if_en         in   1       fetched instruction valid
//  stall         in   1       downstream stall; holds ID/EX latch
//  flush         in   1       kill instruction entering ID/EX (branch/trap)
//  gpr_rs1_addr  out  REG_AW  gpr read port 0 address = if_insn[19:15]
//  gpr_rs2_addr  out  REG_AW  gpr read port 1 address = if_insn[24:20]
//  gpr_rs1_data  in   XLEN    gpr read port 0 data (already 0 for x0, WB-bypassed)
//  gpr_rs2_data  in   XLEN    gpr read port 1 data
//  ex_en         in   1       EX holds valid instruction
//  ex_rd_we      in   1       EX instruction writes rd
//  ex_is_load    in   1       EX instruction is a load (result not ready)
//  ex_rd_addr    in   REG_AW  EX destination
//  ex_fwd_data   in   XLEN    EX ALU result
//  mem_en        in   1       MEM holds valid instruction
//  mem_rd_we     in   1       MEM instruction writes rd
//  mem_rd_addr   in   REG_AW  MEM destination
//  mem_fwd_data  in   XLEN    MEM result (load data or ALU result)
//  ld_hazard     out  1       combinational; IF must hold pc/insn this cycle
//  id_en         out  1       ID/EX valid
//  id_pc         out  XLEN    ID/EX PC
//  id_insn       out  32      ID/EX instruction
//  id_rd_addr    out  REG_AW  ID/EX destination (0 when opcode has no rd)
//  id_rs1_data   out  XLEN    ID/EX forwarded operand 1
//  id_rs2_data   out  XLEN    ID/EX forwarded operand 2
//  id_imm        out  XLEN    ID/EX sign-extended immediate
// BEHAVIOUR
//  - Reset (reset_=0, async): all id_* outputs 0, id_insn = 32'h0000_0013 (NOP).
//  - Latency: one cycle, if_* at edge N appears on id_* after edge N.
//  - Source use: rs1 used unless opcode LUI/AUIPC/JAL.
//    rs2 used only for BRANCH/STORE/OP.
//  - Forward per source: EX match (ex_en & ex_rd_we & !ex_is_load & addr!=0) > MEM match
//    (mem_en & mem_rd_we & addr!=0) > gpr data. x0 is never forwarded; always reads 0.
//  - ld_hazard = if_en & ex_en & ex_is_load & ex_rd_we & ex_rd_addr!=0 & ex_rd_addr equals
//    a used source. It stays high until the load leaves EX.
//  - Immediate, by format (all sign-extended from insn[31]):
//    I (LOAD/OP-IMM/JALR); S (STORE); B (BRANCH), bit0=0; U (LUI/AUIPC), low 12 bits 0;
//    J (JAL), bit0=0; else 0.
//  - Latch update priority per edge:
//    flush  -> id_en=0, id_insn=NOP, id_rd_addr=0, other fields don't-care.
//    stall  -> all id_* hold (ld_hazard still computed).
//    ld_hazard -> bubble: id_en=0, id_insn=NOP, id_rd_addr=0.
//    else   -> load decoded bundle, id_en=if_en.
//  - flush and stall together: flush wins. A flush or bubble never drives a nonzero id_rd_addr.
//  - Reset mid-operation discards the ID/EX contents immediately; first valid id_en follows
//    the first edge after reset_ rises with if_en=1.
//  - gpr_rs*_addr are pure wires from if_insn, independent of stall/hazard.
// TESTING
//  1 Reset: assert reset_=0 mid-run -> id_en=0, id_insn=32'h13 immediately, no clock edge needed.
//  2 ADD x3,x1,x2 with gpr x1=5, x2=7, no hazards
//    -> next edge: id_rs1_data=5, id_rs2_data=7, id_rd_addr=3.
//  3 Forwarding: EX writes x1=0xAA and MEM writes x1=0xBB, ADDI x4,x1,-1
//    -> id_rs1_data=0xAA, id_imm=0xFFFF_FFFF.
//    Repeat with x0 as EX rd -> operand 0.
//  4 Load-use: EX=LW x5, ID=ADD x6,x5,x0 -> ld_hazard=1; next edge id_en=0.
//    When EX load leaves and MEM supplies x5=0x1234 -> id_rs1_data=0x1234.
//    LUI x5 behind the same load -> no hazard.
//  5 Control: stall=1 for 3 cycles -> id_* constant.
//    stall=1 & flush=1 -> id_en=0, id_rd_addr=0.
//  6 Immediates: BEQ imm=-4 -> 0xFFFF_FFFC; JAL +2048 -> 0x0000_0800;
//    SW off 0x7FF -> 0x0000_07FF; AUIPC 0xFFFFF -> 0xFFFF_F000.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage of the FMRT Mini Core: operand fetch with EX/MEM
// forwarding, immediate generation, load-use detection and the ID/EX latch.
module id_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [XLEN-1:0]   if_pc,
   input  logic [31:0]       if_insn,
   input  logic              if_en,
   input  logic              stall,
   input  logic              flush,
   output logic [REG_AW-1:0] gpr_rs1_addr,
   output logic [REG_AW-1:0] gpr_rs2_addr,
   input  logic [XLEN-1:0]   gpr_rs1_data,
   input  logic [XLEN-1:0]   gpr_rs2_data,
   input  logic              ex_en,
   input  logic              ex_rd_we,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic [XLEN-1:0]   ex_fwd_data,
   input  logic              mem_en,
   input  logic              mem_rd_we,
   input  logic [REG_AW-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]   mem_fwd_data,
   output logic              ld_hazard,
   output logic              id_en,
   output logic [XLEN-1:0]   id_pc,
   output logic [31:0]       id_insn,
   output logic [REG_AW-1:0] id_rd_addr,
   output logic [XLEN-1:0]   id_rs1_data,
   output logic [XLEN-1:0]   id_rs2_data,
   output logic [XLEN-1:0]   id_imm
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   logic [6:0]        opcode;
   logic [REG_AW-1:0] rs1_addr;
   logic [REG_AW-1:0] rs2_addr;
   logic [REG_AW-1:0] rd_field;
   logic              rs1_used;
   logic              rs2_used;
   logic              has_rd;
   logic [31:0]       imm32;
   logic [XLEN-1:0]   imm_dec;
   logic [XLEN-1:0]   rs1_fwd;
   logic [XLEN-1:0]   rs2_fwd;
   logic              ex_can_fwd;
   logic              mem_can_fwd;
   logic              ex_load_pending;

   assign opcode   = if_insn[6:0];
   assign rs1_addr = if_insn[15 +: REG_AW];
   assign rs2_addr = if_insn[20 +: REG_AW];
   assign rd_field = if_insn[7 +: REG_AW];

   assign gpr_rs1_addr = rs1_addr;
   assign gpr_rs2_addr = rs2_addr;

   // Format decode: which sources are read, whether rd is written, and the immediate.
   always_comb begin
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      has_rd   = 1'b0;
      imm32    = '0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            rs1_used = 1'b0;
            has_rd   = 1'b1;
            imm32    = {if_insn[31:12], 12'b0};
         end
         OPC_JAL: begin
            rs1_used = 1'b0;
            has_rd   = 1'b1;
            imm32    = {{12{if_insn[31]}}, if_insn[19:12], if_insn[20],
                        if_insn[30:21], 1'b0};
         end
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            has_rd = 1'b1;
            imm32  = {{20{if_insn[31]}}, if_insn[31:20]};
         end
         OPC_STORE: begin
            rs2_used = 1'b1;
            imm32    = {{20{if_insn[31]}}, if_insn[31:25], if_insn[11:7]};
         end
         OPC_BRANCH: begin
            rs2_used = 1'b1;
            imm32    = {{19{if_insn[31]}}, if_insn[31], if_insn[7],
                        if_insn[30:25], if_insn[11:8], 1'b0};
         end
         OPC_OP: begin
            rs2_used = 1'b1;
            has_rd   = 1'b1;
         end
         OPC_SYSTEM: begin
            has_rd = 1'b1;
         end
         default: begin
            rs1_used = 1'b1;
         end
      endcase
   end

   assign imm_dec = XLEN'($signed(imm32));

   // A load in EX has no result yet, so it may never feed the bypass path.
   assign ex_can_fwd      = ex_en & ex_rd_we & ~ex_is_load & (ex_rd_addr != '0);
   assign mem_can_fwd     = mem_en & mem_rd_we & (mem_rd_addr != '0);
   assign ex_load_pending = ex_en & ex_rd_we & ex_is_load & (ex_rd_addr != '0);

   function automatic logic [XLEN-1:0] pick_operand(
      input logic [REG_AW-1:0] addr,
      input logic [XLEN-1:0]   gpr_data,
      input logic              ex_ok,
      input logic [REG_AW-1:0] ex_addr,
      input logic [XLEN-1:0]   ex_data,
      input logic              mem_ok,
      input logic [REG_AW-1:0] mem_addr,
      input logic [XLEN-1:0]   mem_data
   );
      logic [XLEN-1:0] result;
      if (addr == '0)
         result = '0;
      else if (ex_ok && (ex_addr == addr))
         result = ex_data;
      else if (mem_ok && (mem_addr == addr))
         result = mem_data;
      else
         result = gpr_data;
      return result;
   endfunction

   always_comb begin
      rs1_fwd = pick_operand(rs1_addr, gpr_rs1_data, ex_can_fwd, ex_rd_addr, ex_fwd_data,
                             mem_can_fwd, mem_rd_addr, mem_fwd_data);
      rs2_fwd = pick_operand(rs2_addr, gpr_rs2_data, ex_can_fwd, ex_rd_addr, ex_fwd_data,
                             mem_can_fwd, mem_rd_addr, mem_fwd_data);
   end

   assign ld_hazard = if_en & ex_load_pending &
                      ((rs1_used & (rs1_addr == ex_rd_addr)) |
                       (rs2_used & (rs2_addr == ex_rd_addr)));

   // ID/EX latch: flush beats stall, stall beats the load-use bubble.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         id_en       <= 1'b0;
         id_pc       <= '0;
         id_insn     <= NOP_INSN;
         id_rd_addr  <= '0;
         id_rs1_data <= '0;
         id_rs2_data <= '0;
         id_imm      <= '0;
      end else if (flush) begin
         id_en      <= 1'b0;
         id_insn    <= NOP_INSN;
         id_rd_addr <= '0;
      end else if (stall) begin
         id_en <= id_en;
      end else if (ld_hazard) begin
         id_en      <= 1'b0;
         id_insn    <= NOP_INSN;
         id_rd_addr <= '0;
      end else begin
         id_en       <= if_en;
         id_pc       <= if_pc;
         id_insn     <= if_insn;
         id_rd_addr  <= has_rd ? rd_field : '0;
         id_rs1_data <= rs1_fwd;
         id_rs2_data <= rs2_fwd;
         id_imm      <= imm_dec;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued per cycle and
// a monitor compares them after each rising edge.
module tb_id_stage;

   logic        clk;
   logic        reset_;
   logic [31:0] if_pc;
   logic [31:0] if_insn;
   logic        if_en;
   logic        stall;
   logic        flush;
   logic [4:0]  gpr_rs1_addr;
   logic [4:0]  gpr_rs2_addr;
   logic [31:0] gpr_rs1_data;
   logic [31:0] gpr_rs2_data;
   logic        ex_en;
   logic        ex_rd_we;
   logic        ex_is_load;
   logic [4:0]  ex_rd_addr;
   logic [31:0] ex_fwd_data;
   logic        mem_en;
   logic        mem_rd_we;
   logic [4:0]  mem_rd_addr;
   logic [31:0] mem_fwd_data;
   logic        ld_hazard;
   logic        id_en;
   logic [31:0] id_pc;
   logic [31:0] id_insn;
   logic [4:0]  id_rd_addr;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;

   typedef struct {
      string       name;
      logic        full;
      logic        c1;
      logic        c2;
      logic        en;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pushed = 0;
   int   n_popped = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   id_stage dut (
      .clk(clk), .reset_(reset_),
      .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
      .stall(stall), .flush(flush),
      .gpr_rs1_addr(gpr_rs1_addr), .gpr_rs2_addr(gpr_rs2_addr),
      .gpr_rs1_data(gpr_rs1_data), .gpr_rs2_data(gpr_rs2_data),
      .ex_en(ex_en), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
      .ex_rd_addr(ex_rd_addr), .ex_fwd_data(ex_fwd_data),
      .mem_en(mem_en), .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr),
      .mem_fwd_data(mem_fwd_data),
      .ld_hazard(ld_hazard),
      .id_en(id_en), .id_pc(id_pc), .id_insn(id_insn), .id_rd_addr(id_rd_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkVal({e.name, "_en"}, {31'b0, id_en}, {31'b0, e.en});
      checkVal({e.name, "_insn"}, id_insn, e.insn);
      checkVal({e.name, "_rd"}, {27'b0, id_rd_addr}, {27'b0, e.rd});
      if (e.full) begin
         checkVal({e.name, "_pc"}, id_pc, e.pc);
         checkVal({e.name, "_imm"}, id_imm, e.imm);
         if (e.c1) checkVal({e.name, "_rs1"}, id_rs1_data, e.rs1);
         if (e.c2) checkVal({e.name, "_rs2"}, id_rs2_data, e.rs2);
      end
   endtask

   // Monitor: one queued expectation is due after every rising edge it was queued for.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_popped++;
            checkOutput(e);
         end
      end
   end

   task automatic idleInputs();
      if_en = 1'b0; if_pc = '0; if_insn = NOP;
      stall = 1'b0; flush = 1'b0;
      gpr_rs1_data = '0; gpr_rs2_data = '0;
      ex_en = 1'b0; ex_rd_we = 1'b0; ex_is_load = 1'b0; ex_rd_addr = '0; ex_fwd_data = '0;
      mem_en = 1'b0; mem_rd_we = 1'b0; mem_rd_addr = '0; mem_fwd_data = '0;
   endtask

   task automatic exLoad(input logic [4:0] rd);
      ex_en = 1'b1; ex_rd_we = 1'b1; ex_is_load = 1'b1; ex_rd_addr = rd; ex_fwd_data = 32'hDEAD_0000;
   endtask

   // Called at a falling edge with inputs already driven; checks the hazard and queues the latch result.
   task automatic applyStimulus(input string name, input logic hz, input logic full,
                                input logic c1, input logic c2, input logic en,
                                input logic [31:0] pc, input logic [31:0] insn,
                                input logic [4:0] rd, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm);
      exp_t e;
      #1;
      checkVal({name, "_hazard"}, {31'b0, ld_hazard}, {31'b0, hz});
      e.name = name; e.full = full; e.c1 = c1; e.c2 = c2; e.en = en;
      e.pc = pc; e.insn = insn; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
      sb.push_back(e);
      n_pushed++;
      @(negedge clk);
   endtask

   initial begin
      reset_ = 1'b0;
      idleInputs();
      #12;
      checkVal("reset_en", {31'b0, id_en}, 32'd0);
      checkVal("reset_insn", id_insn, NOP);
      checkVal("reset_rd", {27'b0, id_rd_addr}, 32'd0);
      checkVal("reset_imm", id_imm, 32'd0);
      @(negedge clk);
      reset_ = 1'b1;

      // ADD x3,x1,x2
      if_en = 1'b1; if_pc = 32'h100; if_insn = 32'h0020_81B3;
      gpr_rs1_data = 32'd5; gpr_rs2_data = 32'd7;
      #1;
      checkVal("add_rs1_addr", {27'b0, gpr_rs1_addr}, 32'd1);
      checkVal("add_rs2_addr", {27'b0, gpr_rs2_addr}, 32'd2);
      applyStimulus("add", 0, 1, 1, 1, 1, 32'h100, 32'h0020_81B3, 5'd3, 32'd5, 32'd7, 32'd0);

      // ADDI x4,x1,-1 with EX and MEM both writing x1
      if_pc = 32'h104; if_insn = 32'hFFF0_8213; gpr_rs1_data = 32'h55; gpr_rs2_data = '0;
      ex_en = 1; ex_rd_we = 1; ex_rd_addr = 5'd1; ex_fwd_data = 32'hAA;
      mem_en = 1; mem_rd_we = 1; mem_rd_addr = 5'd1; mem_fwd_data = 32'hBB;
      applyStimulus("fwd_ex", 0, 1, 1, 0, 1, 32'h104, 32'hFFF0_8213, 5'd4, 32'hAA, 0, 32'hFFFF_FFFF);

      if_pc = 32'h108; ex_en = 0;
      applyStimulus("fwd_mem", 0, 1, 1, 0, 1, 32'h108, 32'hFFF0_8213, 5'd4, 32'hBB, 0, 32'hFFFF_FFFF);

      if_pc = 32'h10C; ex_en = 1; ex_rd_we = 0;
      applyStimulus("fwd_ex_nowe", 0, 1, 1, 0, 1, 32'h10C, 32'hFFF0_8213, 5'd4, 32'hBB, 0, 32'hFFFF_FFFF);

      // ADDI x4,x0,-1 with EX/MEM targeting x0
      if_pc = 32'h110; if_insn = 32'hFFF0_0213; gpr_rs1_data = 0;
      ex_rd_we = 1; ex_rd_addr = 5'd0; mem_rd_addr = 5'd0;
      applyStimulus("fwd_x0", 0, 1, 1, 0, 1, 32'h110, 32'hFFF0_0213, 5'd4, 32'h0, 0, 32'hFFFF_FFFF);

      // Load-use: LW x5 in EX, ADD x6,x5,x0 in ID
      idleInputs();
      if_en = 1; if_pc = 32'h114; if_insn = 32'h0002_8333; gpr_rs1_data = 32'h777;
      exLoad(5'd5);
      applyStimulus("lduse_bubble", 1, 0, 0, 0, 0, 0, NOP, 5'd0, 0, 0, 0);

      ex_en = 0; ex_rd_we = 0; ex_is_load = 0; ex_rd_addr = 0;
      mem_en = 1; mem_rd_we = 1; mem_rd_addr = 5'd5; mem_fwd_data = 32'h1234;
      applyStimulus("lduse_mem", 0, 1, 1, 1, 1, 32'h114, 32'h0002_8333, 5'd6, 32'h1234, 0, 0);

      idleInputs();
      if_en = 1; if_pc = 32'h118; if_insn = 32'h0002_82B7;
      exLoad(5'd5);
      applyStimulus("lui_noh", 0, 1, 0, 0, 1, 32'h118, 32'h0002_82B7, 5'd5, 0, 0, 32'h0002_8000);

      if_pc = 32'h11C; if_insn = 32'h0050_0333;
      applyStimulus("lduse_rs2", 1, 0, 0, 0, 0, 0, NOP, 5'd0, 0, 0, 0);

      if_pc = 32'h120; if_insn = 32'h0050_0313;
      applyStimulus("addi_noh", 0, 1, 1, 0, 1, 32'h120, 32'h0050_0313, 5'd6, 0, 0, 32'd5);

      if_en = 0; if_pc = 32'h124; if_insn = 32'h0002_8333;
      applyStimulus("noif_noh", 0, 0, 0, 0, 0, 0, 32'h0002_8333, 5'd6, 0, 0, 0);

      // Stall for three cycles while the IF side changes underneath
      idleInputs();
      if_en = 1; if_pc = 32'h200; if_insn = 32'h0020_81B3; gpr_rs1_data = 5; gpr_rs2_data = 7;
      applyStimulus("ctl_load", 0, 1, 1, 1, 1, 32'h200, 32'h0020_81B3, 5'd3, 5, 7, 0);
      stall = 1; if_pc = 32'h204; if_insn = 32'hFFF0_8213; gpr_rs1_data = 9;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) exLoad(5'd1);
         applyStimulus("stall_hold", (i == 2), 1, 1, 1, 1, 32'h200, 32'h0020_81B3, 5'd3, 5, 7, 0);
      end
      ex_en = 0; ex_rd_we = 0; ex_is_load = 0;
      flush = 1;
      applyStimulus("stall_flush", 0, 0, 0, 0, 0, 0, NOP, 5'd0, 0, 0, 0);

      stall = 0; flush = 0; if_pc = 32'h208; if_insn = 32'h0020_81B3; gpr_rs1_data = 5;
      applyStimulus("ctl_reload", 0, 1, 1, 1, 1, 32'h208, 32'h0020_81B3, 5'd3, 5, 7, 0);
      flush = 1; if_pc = 32'h20C;
      applyStimulus("flush", 0, 0, 0, 0, 0, 0, NOP, 5'd0, 0, 0, 0);

      // Immediate formats
      idleInputs();
      if_en = 1; if_pc = 32'h300; if_insn = 32'hFE00_0EE3;
      applyStimulus("imm_beq", 0, 1, 1, 1, 1, 32'h300, 32'hFE00_0EE3, 5'd0, 0, 0, 32'hFFFF_FFFC);
      if_pc = 32'h304; if_insn = 32'h0010_00EF;
      applyStimulus("imm_jal", 0, 1, 0, 0, 1, 32'h304, 32'h0010_00EF, 5'd1, 0, 0, 32'h0000_0800);
      if_pc = 32'h308; if_insn = 32'h7E31_2FA3; gpr_rs1_data = 32'h1000; gpr_rs2_data = 32'hDEAD;
      applyStimulus("imm_sw", 0, 1, 1, 1, 1, 32'h308, 32'h7E31_2FA3, 5'd0, 32'h1000, 32'hDEAD, 32'h0000_07FF);
      if_pc = 32'h30C; if_insn = 32'hFFFF_F397;
      applyStimulus("imm_auipc", 0, 1, 0, 0, 1, 32'h30C, 32'hFFFF_F397, 5'd7, 0, 0, 32'hFFFF_F000);
      if_pc = 32'h310; if_insn = 32'h8000_8403; gpr_rs1_data = 32'h2000;
      applyStimulus("imm_lw", 0, 1, 1, 0, 1, 32'h310, 32'h8000_8403, 5'd8, 32'h2000, 0, 32'hFFFF_F800);

      // Asynchronous reset between edges
      #2;
      reset_ = 1'b0;
      #1;
      checkVal("midreset_en", {31'b0, id_en}, 32'd0);
      checkVal("midreset_insn", id_insn, NOP);
      checkVal("midreset_rd", {27'b0, id_rd_addr}, 32'd0);
      checkVal("midreset_pc", id_pc, 32'd0);
      @(negedge clk);
      reset_ = 1'b1;
      idleInputs();
      if_en = 1; if_pc = 32'h400; if_insn = 32'h0020_81B3; gpr_rs1_data = 3; gpr_rs2_data = 4;
      applyStimulus("post_reset", 0, 1, 1, 1, 1, 32'h400, 32'h0020_81B3, 5'd3, 3, 4, 0);

      idleInputs();
      repeat (3) @(negedge clk);
      checkVal("sb_drained", n_popped, n_pushed);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
